// File: rtl/mac_pkg.sv
// Shared widths and sizing helpers for the pixel/weight MAC datapath.
package mac_pkg;

  localparam int PIXEL_W     = 10;
  localparam int WEIGHT_W    = 19;
  localparam int WEIGHT_FRAC = 18;
  localparam int OUT_W       = 26;
  localparam int OUT_FRAC    = 10;
  localparam int PROD_W      = 29;

  // Number of registered adder levels needed to reduce n operands to one.
  function automatic int TREE_LEVELS(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Operand count entering tree level k (level 0 is the product bank).
  function automatic int LEVEL_COUNT(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/mac_adder_tree_level.sv
// One registered level of the adder tree: pairwise sums grow by one bit, and an
// odd leftover operand is registered unchanged so every path keeps equal latency.
module mac_adder_tree_level
  import mac_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W_IN = PROD_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_IN*W_IN-1:0]                  i_operands,
  output logic [((N_IN+1)/2)*(W_IN+1)-1:0]      o_sums
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int W_OUT = W_IN + 1;

  logic [N_OUT*W_OUT-1:0] w_next;
  logic [N_OUT*W_OUT-1:0] r_sums;

  always_comb begin
    w_next = '0;
    for (int i = 0; i < N_IN / 2; i++) begin
      w_next[i*W_OUT +: W_OUT] = W_OUT'(i_operands[(2*i)*W_IN +: W_IN])
                               + W_OUT'(i_operands[(2*i+1)*W_IN +: W_IN]);
    end
    if (N_IN % 2 == 1) begin
      w_next[(N_OUT-1)*W_OUT +: W_OUT] = W_OUT'(i_operands[(N_IN-1)*W_IN +: W_IN]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sums <= '0;
    end else begin
      r_sums <= w_next;
    end
  end

  assign o_sums = r_sums;

endmodule

// File: rtl/pipelined_mult_accumulate.sv
// Fully pipelined dot product of NUM_INPUTS pixels and Q1.18 weights, giving a
// saturated Q16.10 result one cycle per vector after 2 + TREE_LEVELS stages.
module pipelined_mult_accumulate
  import mac_pkg::*;
#(
  parameter int NUM_INPUTS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PIXEL_W*NUM_INPUTS-1:0]   IN_PIXELS,
  input  logic [WEIGHT_W*NUM_INPUTS-1:0]  IN_WEIGHTS,
  output logic [OUT_W-1:0]                OUT
);

  localparam int T     = TREE_LEVELS(NUM_INPUTS);
  localparam int SUM_W = PROD_W + T;
  localparam int SHIFT = WEIGHT_FRAC - OUT_FRAC;
  localparam int SH_W  = SUM_W - SHIFT;

  logic [NUM_INPUTS*PROD_W-1:0] w_prod;
  logic [NUM_INPUTS*PROD_W-1:0] r_prod;
  logic [SUM_W-1:0]             w_sum;
  logic [SH_W-1:0]              w_shifted;
  logic [OUT_W-1:0]             w_result;
  logic [OUT_W-1:0]             r_out;

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_prod[i*PROD_W +: PROD_W] = PROD_W'(IN_PIXELS[i*PIXEL_W +: PIXEL_W])
                                 * PROD_W'(IN_WEIGHTS[i*WEIGHT_W +: WEIGHT_W]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod <= '0;
    end else begin
      r_prod <= w_prod;
    end
  end

  generate
    for (genvar k = 0; k < T; k++) begin : g_lvl
      localparam int N_K = LEVEL_COUNT(NUM_INPUTS, k);
      localparam int W_K = PROD_W + k;
      logic [N_K*W_K-1:0]                            w_ops;
      logic [LEVEL_COUNT(NUM_INPUTS, k+1)*(W_K+1)-1:0] w_sums;

      if (k == 0) begin : g_first
        assign w_ops = r_prod;
      end else begin : g_next
        assign w_ops = g_lvl[k-1].w_sums;
      end

      mac_adder_tree_level #(
        .N_IN (N_K),
        .W_IN (W_K)
      ) u_level (
        .clk        (clk),
        .rst        (rst),
        .i_operands (w_ops),
        .o_sums     (w_sums)
      );
    end

    if (T == 0) begin : g_no_tree
      assign w_sum = r_prod;
    end else begin : g_tree_out
      assign w_sum = g_lvl[T-1].w_sums;
    end
  endgenerate

  // Q.18 -> Q.10 by truncation; only wide trees can exceed the output range.
  assign w_shifted = SH_W'(w_sum >> SHIFT);

  generate
    if (SH_W > OUT_W) begin : g_sat
      assign w_result = (|w_shifted[SH_W-1:OUT_W]) ? '1 : w_shifted[OUT_W-1:0];
    end else begin : g_nosat
      assign w_result = OUT_W'(w_shifted);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_result;
    end
  end

  assign OUT = r_out;

endmodule

// File: tb/tb_pipelined_mult_accumulate.sv
// Scoreboard bench for the 4-input and 64-input MAC: stimulus pushes hand-computed
// results tagged with the cycle they are due, a negedge monitor pops and compares.
module tb_pipelined_mult_accumulate;

  localparam int L4  = 4;
  localparam int L64 = 8;

  typedef struct {
    int          due;
    logic [25:0] exp;
    string       name;
  } sbEntry_t;

  logic          clk;
  logic          rst;
  logic [39:0]   pix4;
  logic [75:0]   wts4;
  logic [639:0]  pix64;
  logic [1215:0] wts64;
  logic [25:0]   out4;
  logic [25:0]   out64;

  sbEntry_t q4[$];
  sbEntry_t q64[$];
  sbEntry_t mon;
  int cyc = 0;
  int checkCount = 0;
  int passCount = 0;

  assign pix64 = {16{pix4}};
  assign wts64 = {16{wts4}};

  pipelined_mult_accumulate #(.NUM_INPUTS(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .IN_PIXELS  (pix4),
    .IN_WEIGHTS (wts4),
    .OUT        (out4)
  );

  pipelined_mult_accumulate #(.NUM_INPUTS(64)) dut64 (
    .clk        (clk),
    .rst        (rst),
    .IN_PIXELS  (pix64),
    .IN_WEIGHTS (wts64),
    .OUT        (out64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [25:0] actual,
                             input logic [25:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end else begin
      passCount++;
    end
  endtask

  task automatic pushExpected(input int lane, input int due, input logic [25:0] exp,
                              input string name);
    sbEntry_t e;
    e.due  = due;
    e.exp  = exp;
    e.name = name;
    if (lane == 0) q4.push_back(e);
    else           q64.push_back(e);
  endtask

  task automatic applyStimulus(input logic [39:0] pix, input logic [75:0] wts,
                               input logic [25:0] exp4, input logic [25:0] exp64,
                               input string name);
    @(negedge clk);
    #1;
    pix4 = pix;
    wts4 = wts;
    pushExpected(0, cyc + L4,  exp4,  {name, "/n4"});
    pushExpected(1, cyc + L64, exp64, {name, "/n64"});
  endtask

  // The first vector after reset release sees an empty pipeline ahead of it.
  task automatic releaseReset(input logic [39:0] pix, input logic [75:0] wts,
                              input logic [25:0] exp4, input logic [25:0] exp64,
                              input string name);
    @(negedge clk);
    #1;
    pix4 = pix;
    wts4 = wts;
    rst  = 1'b1;
    for (int k = 1; k < L4; k++)  pushExpected(0, cyc + k, 26'd0, "post-reset zero/n4");
    for (int k = 1; k < L64; k++) pushExpected(1, cyc + k, 26'd0, "post-reset zero/n64");
    pushExpected(0, cyc + L4,  exp4,  {name, "/n4"});
    pushExpected(1, cyc + L64, exp64, {name, "/n64"});
  endtask

  always @(negedge clk) begin
    while (q4.size() > 0 && q4[0].due <= cyc) begin
      mon = q4.pop_front();
      checkOutput(mon.name, out4, mon.exp);
    end
    while (q64.size() > 0 && q64[0].due <= cyc) begin
      mon = q64.pop_front();
      checkOutput(mon.name, out64, mon.exp);
    end
  end

  initial begin
    logic [39:0] pAll50, pMixed, pOne, pMax;
    logic [75:0] wQuarter, wMixed, wPrec, wMax;
    pAll50   = {4{10'd50}};
    wQuarter = {4{19'h10000}};
    pMixed   = {10'd200, 10'd150, 10'd100, 10'd50};
    wMixed   = {19'h04000, 19'h02000, 19'h08000, 19'h10000};
    pOne     = {30'd0, 10'd1};
    wPrec    = {57'd0, 19'd300};
    pMax     = {4{10'h3FF}};
    wMax     = {4{19'h7FFFF}};

    rst  = 1'b1;
    pix4 = '0;
    wts4 = '0;
    #2;
    rst  = 1'b0;
    pix4 = pAll50;
    wts4 = wQuarter;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("in reset/n4", out4, 26'd0);
      checkOutput("in reset/n64", out64, 26'd0);
    end

    releaseReset(pAll50, wQuarter, 26'd51200, 26'd819200, "all50");
    repeat (3) applyStimulus(pAll50, wQuarter, 26'd51200, 26'd819200, "all50 held");

    for (int j = 1; j <= 6; j++) begin
      applyStimulus({4{10'(j)}}, wQuarter, 26'(j * 1024), 26'(j * 16384),
                    $sformatf("stream%0d", j));
    end

    // Streamed vectors are still in flight here and must be discarded.
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async clear/n4", out4, 26'd0);
    checkOutput("async clear/n64", out64, 26'd0);
    q4.delete();
    q64.delete();
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("hold reset/n4", out4, 26'd0);
      checkOutput("hold reset/n64", out64, 26'd0);
    end

    releaseReset(pMixed, wMixed, 26'd43200, 26'd691200, "mixed");
    applyStimulus(pOne, wPrec, 26'd1, 26'd18, "truncate");
    repeat (3) applyStimulus(pMax, wMax, 26'd8380400, 26'h3FFFFFF, "max");

    for (int n = 0; n < 20; n++) begin
      if (q4.size() == 0 && q64.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("scoreboard drained", 26'(q4.size() + q64.size()), 26'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
